// File: rtl/onewire_pkg.sv
// onewire_pkg: shared states, command codes and slot timing (us)
// for the 1-Wire bus master.
package onewire_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_SLOT_LOW,
    S_SLOT_REL,
    S_SLOT_REC,
    S_DONE
  } state_t;

  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  localparam logic [8:0] T_RST_LOW     = 9'd480;
  localparam logic [8:0] T_PRES_SAMPLE = 9'd70;
  localparam logic [8:0] T_RST_REL     = 9'd480;
  localparam logic [8:0] T_LOW1        = 9'd6;
  localparam logic [8:0] T_LOW0        = 9'd60;
  localparam logic [8:0] T_REL1        = 9'd64;
  localparam logic [8:0] T_REL0        = 9'd10;
  localparam logic [8:0] T_RD_SAMPLE   = 9'd9;
  localparam logic [8:0] T_RD_REC      = 9'd55;
  localparam logic [8:0] T_GAP         = 9'd1;

  function automatic logic [8:0] low_time(
    input logic rd,
    input logic b
  );
    return (rd | b) ? T_LOW1 : T_LOW0;
  endfunction

  function automatic logic [8:0] rel_time(
    input logic rd,
    input logic b
  );
    if (rd) return T_RD_SAMPLE;
    return b ? T_REL1 : T_REL0;
  endfunction

endpackage

// File: rtl/onewire_us_timer.sv
// onewire_us_timer: microsecond prescaler plus a loadable 9-bit
// us down-counter; o_expired pulses on the last tick of a phase.
module onewire_us_timer #(
  parameter int US_DIV = 24
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic       i_load,
  input  logic [8:0] i_dur,
  output logic       o_expired
);

  localparam int PW = (US_DIV > 2) ? $clog2(US_DIV) : 1;

  logic [PW-1:0] r_pre;
  logic [8:0]    r_cnt;
  logic          w_tick;

  assign w_tick    = (r_pre == PW'(US_DIV - 1));
  assign o_expired = w_tick & (r_cnt == 9'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      if (i_restart | w_tick) r_pre <= '0;
      else                    r_pre <= r_pre + 1'b1;
      if (i_load)
        r_cnt <= i_dur;
      else if (w_tick && r_cnt != 9'd0)
        r_cnt <= r_cnt - 9'd1;
    end
  end

endmodule

// File: rtl/onewire_master.sv
// onewire_master: 1-Wire reset/presence, write-byte and read-byte
// transactions with standard-speed slot timing.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 24000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd,
  input  logic [7:0] i_wr_data,
  output logic       o_ready,
  output logic       o_done,
  output logic [7:0] o_rd_data,
  output logic       o_presence,
  input  logic       i_owr,
  output logic       o_owr
);

  localparam int US_DIV = CLK_FREQ_HZ / 1000000;

  state_t     r_state;
  logic       r_owr;
  logic       r_ready;
  logic       r_done;
  logic [7:0] r_rd_data;
  logic       r_presence;
  logic [7:0] r_shift;
  logic [7:0] r_byte;
  logic [2:0] r_bit;
  logic       r_ph;
  logic       r_rd;
  logic       r_pres;
  logic [1:0] r_sync;

  logic       w_bus;
  logic       w_accept;
  logic       w_load;
  logic       w_exp;
  logic [8:0] w_dur;

  assign w_bus    = r_sync[1];
  assign w_accept = i_cmd_valid & r_ready & (i_cmd != 2'b11);

  assign o_owr      = r_owr;
  assign o_ready    = r_ready;
  assign o_done     = r_done;
  assign o_rd_data  = r_rd_data;
  assign o_presence = r_presence;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_owr};
  end

  // Each phase is loaded when the previous one expires, so the
  // prescaler stays aligned to the acceptance edge.
  always_comb begin
    w_load = 1'b0;
    w_dur  = '0;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
        w_load = 1'b1;
        w_dur  = (i_cmd == CMD_RESET) ? T_RST_LOW :
                 low_time(i_cmd == CMD_READ, i_wr_data[0]);
      end
      S_RST_LOW: if (w_exp) begin
        w_load = 1'b1;
        w_dur  = T_PRES_SAMPLE;
      end
      S_RST_WAIT: if (w_exp && !r_ph) begin
        w_load = 1'b1;
        w_dur  = T_RST_REL - T_PRES_SAMPLE;
      end
      S_SLOT_LOW: if (w_exp) begin
        w_load = 1'b1;
        w_dur  = rel_time(r_rd, r_byte[0]);
      end
      S_SLOT_REL: if (w_exp) begin
        w_load = 1'b1;
        w_dur  = (r_rd && !r_ph) ? T_RD_REC : T_GAP;
      end
      S_SLOT_REC: if (w_exp && r_bit != 3'd7) begin
        w_load = 1'b1;
        w_dur  = low_time(r_rd, r_byte[1]);
      end
      default: ;
    endcase
  end

  onewire_us_timer #(
    .US_DIV (US_DIV)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_accept),
    .i_load    (w_load),
    .i_dur     (w_dur),
    .o_expired (w_exp)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_owr      <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_rd_data  <= '0;
      r_presence <= 1'b0;
      r_shift    <= '0;
      r_byte     <= '0;
      r_bit      <= '0;
      r_ph       <= 1'b0;
      r_rd       <= 1'b0;
      r_pres     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_ready <= 1'b0;
          r_owr   <= 1'b1;
          r_bit   <= '0;
          r_ph    <= 1'b0;
          r_shift <= '0;
          r_byte  <= i_wr_data;
          r_rd    <= (i_cmd == CMD_READ);
          r_state <= (i_cmd == CMD_RESET) ? S_RST_LOW : S_SLOT_LOW;
        end
        S_RST_LOW: if (w_exp) begin
          r_owr   <= 1'b0;
          r_ph    <= 1'b0;
          r_state <= S_RST_WAIT;
        end
        S_RST_WAIT: if (w_exp) begin
          if (!r_ph) begin
            r_pres <= ~w_bus;
            r_ph   <= 1'b1;
          end else begin
            r_presence <= r_pres;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_SLOT_LOW: if (w_exp) begin
          r_owr   <= 1'b0;
          r_ph    <= 1'b0;
          r_state <= S_SLOT_REL;
        end
        S_SLOT_REL: if (w_exp) begin
          if (r_rd && !r_ph) begin
            r_shift[r_bit] <= w_bus;
            r_ph           <= 1'b1;
          end else begin
            r_state <= S_SLOT_REC;
          end
        end
        S_SLOT_REC: if (w_exp) begin
          if (r_bit == 3'd7) begin
            if (r_rd) r_rd_data <= r_shift;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_bit   <= r_bit + 3'd1;
            r_byte  <= {1'b0, r_byte[7:1]};
            r_owr   <= 1'b1;
            r_state <= S_SLOT_LOW;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master: directed/random checks of the 1-Wire master
// against a pull-up + slave model and slot-rule expectations.
`timescale 1ns/1ps
module tb_onewire_master;

  localparam int FREQ  = 8000000;
  localparam int DIV   = FREQ / 1000000;
  localparam int US    = DIV * 10;
  localparam int LIMIT = 1100 * DIV;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic [1:0] i_cmd = 2'b00;
  logic [7:0] i_wr_data = 8'h00;
  logic       o_ready;
  logic       o_done;
  logic [7:0] o_rd_data;
  logic       o_presence;
  logic       i_owr;
  logic       o_owr;

  logic pull_p = 1'b0;
  logic pull_r = 1'b0;
  logic stuck_low = 1'b0;
  logic pres_en = 1'b0;
  logic sl_bit;
  int   pres_dly = 30;
  logic rdq[$];
  int   lowq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign i_owr = ~(o_owr | pull_p | pull_r | stuck_low);

  onewire_master #(.CLK_FREQ_HZ(FREQ)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd       (i_cmd),
    .i_wr_data   (i_wr_data),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_rd_data   (o_rd_data),
    .o_presence  (o_presence),
    .i_owr       (i_owr),
    .o_owr       (o_owr)
  );

  // presence pulse: starts pres_dly us after release, ends at 255 us
  always @(negedge o_owr) begin
    if (pres_en) begin
      #(pres_dly * US);
      pull_p = 1'b1;
      #((255 - pres_dly) * US);
      pull_p = 1'b0;
    end
  end

  // read slave: a 0-bit holds the bus low 30 us from slot start
  always @(posedge o_owr) begin
    if (rdq.size() != 0) begin
      sl_bit = rdq.pop_front();
      if (!sl_bit) begin
        pull_r = 1'b1;
        #(30 * US);
        pull_r = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d,
                         input int inj_at, input int rst_at,
                         output int cyc, output int nd);
    int  run;
    bit  fin;
    lowq.delete();
    run = 0;
    nd  = 0;
    fin = 0;
    cyc = 0;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    i_wr_data   = d;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_wr_data   = 8'h00;
    while (!fin && cyc < LIMIT) begin
      cyc++;
      if (o_owr) run++;
      else if (run != 0) begin
        lowq.push_back(run);
        run = 0;
      end
      if (o_done) begin
        nd++;
        fin = 1;
      end
      if (cyc == inj_at) begin
        i_cmd_valid = 1'b1;
        i_cmd       = 2'b10;
        i_wr_data   = 8'hFF;
      end else if (cyc == inj_at + 1) begin
        i_cmd_valid = 1'b0;
        i_wr_data   = 8'h00;
      end
      if (cyc == rst_at + 1) fin = 1;
      if (cyc == rst_at) i_rst = 1'b1;
      if (!fin) @(negedge clk);
    end
  endtask

  task automatic idle_watch(input int n, output int nd,
                            output int nbusy, output int nowr);
    nd = 0;
    nbusy = 0;
    nowr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_done)   nd++;
      if (!o_ready) nbusy++;
      if (o_owr)    nowr++;
    end
  endtask

  task automatic do_write(input string tag, input logic [7:0] b,
                          input int inj_at);
    int cyc, nd, x, y, z;
    run_cmd(2'b01, b, inj_at, -1, cyc, nd);
    chk({tag, "_npulse"}, lowq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      x = (b[i] ? 6 : 60) * DIV;
      if (i < lowq.size()) chk({tag, "_low"}, lowq[i], x);
      else                 chk({tag, "_low_missing"}, -1, x);
    end
    chk_rng({tag, "_total"}, cyc, 568 * DIV - DIV, 568 * DIV + DIV);
    chk({tag, "_done"}, nd, 1);
    idle_watch(40, x, y, z);
    chk({tag, "_extra_done"}, x, 0);
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp,
                         input bit load_slave);
    int cyc, nd;
    if (load_slave)
      for (int i = 0; i < 8; i++) rdq.push_back(exp[i]);
    run_cmd(2'b10, 8'h00, -1, -1, cyc, nd);
    chk({tag, "_done"}, nd, 1);
    chk({tag, "_data"}, int'(o_rd_data), int'(exp));
    chk_rng({tag, "_total"}, cyc, 568 * DIV - DIV, 568 * DIV + DIV);
    rdq.delete();
  endtask

  initial begin
    int cyc, nd, nbusy, nowr;
    logic [7:0] rb;

    repeat (4) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_owr", int'(o_owr), 0);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_done", int'(o_done), 0);
    chk("rst_rd_data", int'(o_rd_data), 0);
    chk("rst_presence", int'(o_presence), 0);

    pres_dly = $urandom_range(15, 60);
    pres_en  = 1'b1;
    run_cmd(2'b00, 8'h00, -1, -1, cyc, nd);
    pres_en  = 1'b0;
    if (lowq.size() > 0)
      chk_rng("pres_rst_low", lowq[0], 480 * DIV - DIV, 480 * DIV + DIV);
    else
      chk("pres_rst_low_missing", 0, 480 * DIV);
    chk("pres_presence", int'(o_presence), 1);
    chk_rng("pres_total", cyc, 960 * DIV - DIV, 960 * DIV + DIV);
    chk("pres_done", nd, 1);

    run_cmd(2'b00, 8'h00, -1, -1, cyc, nd);
    chk("noslave_presence", int'(o_presence), 0);
    chk("noslave_npulse", lowq.size(), 1);
    chk("noslave_done", nd, 1);

    do_write("wr_a5", 8'hA5, -1);
    do_write("wr_rand", 8'($urandom), -1);
    do_write("wr_busy", 8'($urandom), 100 * DIV);

    do_read("rd_3c", 8'h3C, 1'b1);
    rb = 8'($urandom);
    do_read("rd_rand", rb, 1'b1);
    do_read("rd_high", 8'hFF, 1'b0);
    stuck_low = 1'b1;
    do_read("rd_low", 8'h00, 1'b0);
    stuck_low = 1'b0;

    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd       = 2'b11;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    idle_watch(200, nd, nbusy, nowr);
    chk("ill_done", nd, 0);
    chk("ill_busy", nbusy, 0);
    chk("ill_owr", nowr, 0);

    rb = 8'($urandom);
    for (int i = 0; i < 8; i++) rdq.push_back(rb[i]);
    run_cmd(2'b10, 8'h00, -1, 100 * DIV, cyc, nd);
    chk("abort_owr", int'(o_owr), 0);
    chk("abort_ready", int'(o_ready), 1);
    chk("abort_rd_data", int'(o_rd_data), 0);
    chk("abort_done", nd, 0);
    i_rst = 1'b0;
    rdq.delete();
    idle_watch(40 * DIV, nd, nbusy, nowr);
    chk("abort_late_done", nd, 0);

    pres_dly = $urandom_range(15, 60);
    pres_en  = 1'b1;
    run_cmd(2'b00, 8'h00, -1, -1, cyc, nd);
    pres_en  = 1'b0;
    chk("post_presence", int'(o_presence), 1);
    chk("post_done", nd, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
